// File: rtl/vmul_seq_pkg.sv
// Shared vector-unit definitions: default widths, sequencer state encoding and
// the fixed latency of the paired multiplier.
package vmul_seq_pkg;

  localparam int VS_DATA_WIDTH  = 64;
  localparam int VS_ADDR_WIDTH  = 32;
  localparam int VS_SEW_WIDTH   = 2;
  localparam int VS_OPSEL_WIDTH = 2;
  localparam int VS_VL_WIDTH    = 11;
  localparam int VS_OUT_WIDTH   = 4;
  localparam int MUL_LATENCY    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vmul_state_e;

endpackage

// File: rtl/vmul_seq.sv
// Vector multiply sequencer: reads operand beats from the register file, feeds
// the multiplier one beat per cycle and writes its results back with a tail mask.
//
// state | meaning
// IDLE  | waiting for an instruction, req_ready high
// ISSUE | requesting operand reads, one beat per grant
// DRAIN | all beats issued, waiting for multiplier results to be written
// DONE  | one-cycle completion pulse
module vmul_seq
  import vmul_seq_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = VS_DATA_WIDTH,
  parameter int REQ_DW_B       = REQ_DATA_WIDTH / 8,
  parameter int REQ_ADDR_WIDTH = VS_ADDR_WIDTH,
  parameter int SEW_WIDTH      = VS_SEW_WIDTH,
  parameter int OPSEL_WIDTH    = VS_OPSEL_WIDTH,
  parameter int VL_WIDTH       = VS_VL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [VL_WIDTH-1:0]       req_vl,
  input  logic [SEW_WIDTH-1:0]      req_sew,
  input  logic [OPSEL_WIDTH-1:0]    req_opsel,
  input  logic                      req_widen,
  input  logic                      req_fxp,
  input  logic [REQ_ADDR_WIDTH-1:0] req_vs1,
  input  logic [REQ_ADDR_WIDTH-1:0] req_vs2,
  input  logic [REQ_ADDR_WIDTH-1:0] req_vd,
  output logic                      rd_req,
  input  logic                      rd_gnt,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr1,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data1,
  output logic [REQ_DATA_WIDTH-1:0] mul_vec0,
  output logic [REQ_DATA_WIDTH-1:0] mul_vec1,
  output logic                      mul_valid,
  output logic [SEW_WIDTH-1:0]      mul_sew,
  output logic [OPSEL_WIDTH-1:0]    mul_opsel,
  output logic                      mul_widen,
  output logic                      mul_fxp,
  output logic [REQ_ADDR_WIDTH-1:0] mul_addr,
  input  logic                      mul_out_valid,
  input  logic [REQ_DATA_WIDTH-1:0] mul_out_vec,
  input  logic [REQ_ADDR_WIDTH-1:0] mul_out_addr,
  output logic                      wr_en,
  output logic [REQ_ADDR_WIDTH-1:0] wr_addr,
  output logic [REQ_DATA_WIDTH-1:0] wr_data,
  output logic [REQ_DW_B-1:0]       wr_be,
  output logic                      done
);

  // Byte count is vl << sew, so it needs (2^SEW_WIDTH - 1) extra bits.
  localparam int BYTES_W = VL_WIDTH + (1 << SEW_WIDTH) - 1;
  localparam int BSH     = $clog2(REQ_DW_B);
  localparam int NB_W    = BYTES_W - BSH + 1;
  localparam int AW      = REQ_ADDR_WIDTH;

  vmul_state_e r_state;
  vmul_state_e w_next;

  logic [NB_W-1:0]         r_nbeats;
  logic [NB_W-1:0]         r_beat;
  logic [BSH-1:0]          r_tail;
  logic [AW-1:0]           r_vs1;
  logic [AW-1:0]           r_vs2;
  logic [AW-1:0]           r_vd;
  logic [AW-1:0]           r_last_addr;
  logic [SEW_WIDTH-1:0]    r_sew;
  logic [OPSEL_WIDTH-1:0]  r_opsel;
  logic                    r_widen;
  logic                    r_fxp;
  logic                    r_mul_valid;
  logic [AW-1:0]           r_mul_addr;
  logic [VS_OUT_WIDTH-1:0] r_outstanding;
  logic                    r_wr_en;
  logic [AW-1:0]           r_wr_addr;
  logic [REQ_DATA_WIDTH-1:0] r_wr_data;
  logic [REQ_DW_B-1:0]     r_wr_be;

  logic [BYTES_W-1:0] w_bytes;
  logic [NB_W-1:0]    w_nbeats;
  logic [AW-1:0]      w_beat_ext;
  logic [AW-1:0]      w_nbeats_ext;
  logic               w_accept;
  logic               w_grant;
  logic               w_last_grant;
  logic               w_out_acc;
  logic [REQ_DW_B-1:0] w_tail_mask;

  assign w_bytes      = BYTES_W'(req_vl) << req_sew;
  assign w_nbeats     = NB_W'((w_bytes + BYTES_W'(REQ_DW_B - 1)) >> BSH);
  assign w_beat_ext   = AW'(r_beat);
  assign w_nbeats_ext = AW'(w_nbeats);
  assign w_accept     = req_valid && (r_state == ST_IDLE);
  assign w_grant      = (r_state == ST_ISSUE) && rd_gnt;
  assign w_last_grant = w_grant && (r_beat == (r_nbeats - NB_W'(1)));
  assign w_out_acc    = mul_out_valid && (r_state != ST_IDLE);
  assign w_tail_mask  = REQ_DW_B'((32'd1 << r_tail) - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = (req_vl == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (w_last_grant) w_next = ST_DRAIN;
      // The final beat's mul_valid may still be in flight on the first DRAIN cycle.
      ST_DRAIN: if ((r_outstanding == '0) && !r_mul_valid && !mul_out_valid) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nbeats    <= '0;
      r_tail      <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_vd        <= '0;
      r_last_addr <= '0;
      r_sew       <= '0;
      r_opsel     <= '0;
      r_widen     <= 1'b0;
      r_fxp       <= 1'b0;
    end else if (w_accept) begin
      r_nbeats    <= w_nbeats;
      r_tail      <= w_bytes[BSH-1:0];
      r_vs1       <= req_vs1;
      r_vs2       <= req_vs2;
      r_vd        <= req_vd;
      r_last_addr <= req_vd + w_nbeats_ext - AW'(1);
      r_sew       <= req_sew;
      r_opsel     <= req_opsel;
      r_widen     <= req_widen;
      r_fxp       <= req_fxp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat        <= '0;
      r_mul_valid   <= 1'b0;
      r_mul_addr    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_accept)     r_beat <= '0;
      else if (w_grant) r_beat <= r_beat + NB_W'(1);
      r_mul_valid <= w_grant;
      r_mul_addr  <= w_grant ? (r_vd + w_beat_ext) : '0;
      case ({r_mul_valid, w_out_acc})
        2'b10:   r_outstanding <= r_outstanding + VS_OUT_WIDTH'(1);
        2'b01:   r_outstanding <= r_outstanding - VS_OUT_WIDTH'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_be   <= '0;
    end else begin
      r_wr_en <= w_out_acc;
      if (w_out_acc) begin
        r_wr_addr <= mul_out_addr;
        r_wr_data <= mul_out_vec;
        r_wr_be   <= ((mul_out_addr == r_last_addr) && (r_tail != '0)) ? w_tail_mask : '1;
      end else begin
        r_wr_addr <= '0;
        r_wr_data <= '0;
        r_wr_be   <= '0;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rd_req    = (r_state == ST_ISSUE);
  assign rd_addr0  = rd_req ? (r_vs1 + w_beat_ext) : '0;
  assign rd_addr1  = rd_req ? (r_vs2 + w_beat_ext) : '0;
  // Read data arrives the cycle after grant, which is exactly the mul_valid cycle.
  assign mul_vec0  = r_mul_valid ? rd_data0 : '0;
  assign mul_vec1  = r_mul_valid ? rd_data1 : '0;
  assign mul_valid = r_mul_valid;
  assign mul_addr  = r_mul_addr;
  assign mul_sew   = r_sew;
  assign mul_opsel = r_opsel;
  assign mul_widen = r_widen;
  assign mul_fxp   = r_fxp;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_be     = r_wr_be;
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_vmul_seq.sv
// Self-checking bench for vmul_seq with a register-file model, a fixed-latency
// multiplier model and a per-instruction expected-write list.
module tb_vmul_seq;
  import vmul_seq_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_vl;
  logic [1:0]  req_sew;
  logic [1:0]  req_opsel;
  logic        req_widen;
  logic        req_fxp;
  logic [31:0] req_vs1, req_vs2, req_vd;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr0, rd_addr1;
  logic [63:0] rd_data0, rd_data1;
  logic [63:0] mul_vec0, mul_vec1;
  logic        mul_valid;
  logic [1:0]  mul_sew, mul_opsel;
  logic        mul_widen, mul_fxp;
  logic [31:0] mul_addr;
  logic        mul_out_valid;
  logic [63:0] mul_out_vec;
  logic [31:0] mul_out_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        done;

  vmul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl),
    .req_sew(req_sew), .req_opsel(req_opsel), .req_widen(req_widen), .req_fxp(req_fxp),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .mul_vec0(mul_vec0), .mul_vec1(mul_vec1), .mul_valid(mul_valid),
    .mul_sew(mul_sew), .mul_opsel(mul_opsel), .mul_widen(mul_widen), .mul_fxp(mul_fxp),
    .mul_addr(mul_addr),
    .mul_out_valid(mul_out_valid), .mul_out_vec(mul_out_vec), .mul_out_addr(mul_out_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_val(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, a * 32'h9E3779B1};
  endfunction

  function automatic logic [63:0] mulf(input logic [63:0] a, input logic [63:0] b);
    return a * b + 64'h1;
  endfunction

  // Register file: data for a granted read appears the next cycle.
  always @(posedge clk) begin
    if (rd_req && rd_gnt) begin
      rd_data0 <= mem_val(rd_addr0);
      rd_data1 <= mem_val(rd_addr1);
    end
  end

  // Multiplier: fixed latency, not reset, so results survive a sequencer reset.
  logic [MUL_LATENCY-1:0] pv = '0;
  logic [63:0] pd [MUL_LATENCY];
  logic [31:0] pa [MUL_LATENCY];
  always @(posedge clk) begin
    pv    <= {pv[MUL_LATENCY-2:0], mul_valid};
    pd[0] <= mulf(mul_vec0, mul_vec1);
    pa[0] <= mul_addr;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      pd[i] <= pd[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mul_out_valid = pv[MUL_LATENCY-1];
  assign mul_out_vec   = pd[MUL_LATENCY-1];
  assign mul_out_addr  = pa[MUL_LATENCY-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_exp_t     exp_q[$];
  logic [31:0] cur_vs1, cur_vs2;
  logic [1:0]  cur_sew, cur_opsel;
  logic        cur_widen, cur_fxp;
  int grant_cnt = 0, n_mulv = 0, n_wr = 0, n_done = 0, n_rdreq = 0;
  int first_gnt = -1, last_gnt = -1, last_wr_cyc = -1, done_cyc = -1;
  int stall_at = -1, stall_len = 0, stall_done = 0;
  int peak = 0;
  bit overlap = 0;
  bit gnt_rand = 0;

  always @(negedge clk) begin
    logic g;
    wr_exp_t e;
    if (!rst_n) begin
      rd_gnt = 1'b0;
    end else begin
      if (rd_req) begin
        n_rdreq++;
        check("rd_addr0", rd_addr0, cur_vs1 + 32'(grant_cnt));
        check("rd_addr1", rd_addr1, cur_vs2 + 32'(grant_cnt));
        check("busy_ready", req_ready, 1'b0);
      end
      if (mul_valid) begin
        n_mulv++;
        check("mul_ops", {mul_sew, mul_opsel, mul_widen, mul_fxp},
              {cur_sew, cur_opsel, cur_widen, cur_fxp});
      end
      if (mul_valid && mul_out_valid) overlap = 1;
      if (int'(dut.r_outstanding) > peak) peak = int'(dut.r_outstanding);
      if (wr_en) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("wr_spurious", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("wr_be", wr_be, e.be);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      g = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_req && grant_cnt == stall_at && stall_done < stall_len) begin
        g = 1'b0;
        stall_done++;
      end
      rd_gnt = g;
      if (rd_req && g) begin
        if (first_gnt < 0) first_gnt = cyc;
        last_gnt = cyc;
        grant_cnt++;
      end
    end
  end

  int accept_cyc;
  int nb_cur;

  task automatic start_instr(input int vl, input int sew, input logic [31:0] vs1,
                             input logic [31:0] vs2, input logic [31:0] vd);
    int bytes, tail, k;
    wr_exp_t e;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", req_ready, 1'b1);
    bytes  = vl << sew;
    nb_cur = (bytes + 7) / 8;
    tail   = bytes % 8;
    exp_q.delete();
    for (int b = 0; b < nb_cur; b++) begin
      e.addr = vd + 32'(b);
      e.data = mulf(mem_val(vs1 + 32'(b)), mem_val(vs2 + 32'(b)));
      e.be   = (b == nb_cur - 1 && tail != 0) ? 8'((1 << tail) - 1) : 8'hFF;
      exp_q.push_back(e);
    end
    cur_vs1 = vs1; cur_vs2 = vs2; cur_sew = 2'(sew);
    cur_opsel = 2'($urandom_range(0, 3)); cur_widen = 1'($urandom_range(0, 1));
    cur_fxp = 1'($urandom_range(0, 1));
    grant_cnt = 0; n_mulv = 0; n_wr = 0; n_done = 0; n_rdreq = 0;
    first_gnt = -1; last_gnt = -1; last_wr_cyc = -1; done_cyc = -1;
    stall_done = 0; peak = 0; overlap = 0;
    req_vl = 11'(vl); req_sew = 2'(sew); req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    req_opsel = cur_opsel; req_widen = cur_widen; req_fxp = cur_fxp;
    req_valid = 1'b1;
    accept_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_instr(input int vl);
    int k;
    k = 0;
    while (n_done == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (n_done == 0) check("done_timeout", 1'b0, 1'b1);
    @(negedge clk);
    check("done_pulses", n_done, 1);
    check("wr_count", n_wr, nb_cur);
    check("mulv_count", n_mulv, nb_cur);
    check("writes_left", exp_q.size(), 0);
    if (vl == 0) begin
      check("vl0_done_lat", ((done_cyc - accept_cyc) >= 1) && ((done_cyc - accept_cyc) <= 2), 1'b1);
      check("vl0_no_rdreq", n_rdreq, 0);
    end else begin
      check("done_after_wr", done_cyc - last_wr_cyc, 1);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_vl = '0; req_sew = '0; req_opsel = '0;
    req_widen = 1'b0; req_fxp = 1'b0; req_vs1 = '0; req_vs2 = '0; req_vd = '0;
    rd_gnt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_ctl", {rd_req, mul_valid, wr_en, done}, 4'b0);
    check("rst_addr", {rd_addr0, rd_addr1, mul_addr, wr_addr}, 128'(0));
    check("rst_be", wr_be, 8'h0);
    rst_n = 1'b1;

    // vl=20 sew=0: three beats, tail of 4 bytes
    start_instr(20, 0, 32'h10, 32'h20, 32'h30);
    finish_instr(20);
    check("rd_span_3", last_gnt - first_gnt, 2);

    // vl=0: straight to completion
    start_instr(0, 1, 32'h40, 32'h50, 32'h60);
    finish_instr(0);

    // grant held low for 3 cycles at beat 1
    stall_at = 1; stall_len = 3;
    start_instr(4, 2, 32'h100, 32'h200, 32'h300);
    finish_instr(4);
    check("stall_cycles", stall_done, 3);
    stall_at = -1; stall_len = 0;

    // 8 beats back to back: pipeline fills to MUL_LATENCY
    start_instr(8, 3, 32'h1000, 32'h2000, 32'h3000);
    finish_instr(8);
    check("rd_span_8", last_gnt - first_gnt, 7);
    check("peak_outst", peak, MUL_LATENCY);
    check("overlap", overlap, 1'b1);

    // reset after 3 beats granted
    start_instr(40, 3, 32'h500, 32'h600, 32'h700);
    k = 0;
    while (grant_cnt < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_ctl", {rd_req, mul_valid, wr_en, done}, 4'b0);
    check("midrst_addr", {rd_addr0, rd_addr1, mul_addr, wr_addr}, 128'(0));
    check("midrst_data", {mul_vec0, wr_data}, 128'(0));
    exp_q.delete();
    n_wr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("late_no_wr", n_wr, 0);

    start_instr(13, 1, 32'h800, 32'h900, 32'hA00);
    finish_instr(13);

    gnt_rand = 1;
    for (int i = 0; i < 15; i++) begin
      int vl, sew;
      vl  = $urandom_range(0, 40);
      sew = $urandom_range(0, 3);
      start_instr(vl, sew, $urandom, $urandom, $urandom);
      finish_instr(vl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
